touch_spi_reader: RTL and testbench

Polls the XPT2046 resistive-touch controller over SPI and produces debounced, screen-scaled touch coordinates in the format the keypad touch decoder consumes. It sits between the LCD board's touch SPI pins and the keypad decode logic. `touch_valid` is a clean level with no chatter, so a single rising edge in the decoder maps to exactly one key press.

---
 rtl/touch_spi_reader.sv | 236 +++++++++++++++++++++++
 tb/tb_touch_spi_reader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_spi_reader.sv
// touch_spi_reader: polls an XPT2046 resistive-touch controller over SPI mode 0
// and produces debounced, screen-scaled touch coordinates for the keypad decoder.
module touch_spi_reader #(
    parameter int CLK_DIV       = 25,
    parameter int POLL_CYCLES   = 500000,
    parameter int Z_THRESH      = 100,
    parameter int PRESS_COUNT   = 2,
    parameter int RELEASE_COUNT = 2,
    parameter int X_MIN         = 200,
    parameter int X_MAX         = 3900,
    parameter int X_SCALE       = 354,
    parameter int Y_MIN         = 200,
    parameter int Y_MAX         = 3900,
    parameter int Y_SCALE       = 266
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_miso,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       touch_valid,
    output logic [9:0] touch_x,
    output logic [8:0] touch_y,
    output logic       sample_strobe
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(POLL_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_EVAL
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [DW-1:0]   r_div;
    logic [PW-1:0]   r_poll_cnt;
    logic            r_pending;
    logic            r_sclk;
    logic [4:0]      r_bit;
    logic [15:0]     r_rx;
    logic [1:0]      r_ch;
    logic [11:0]     r_z;
    logic [11:0]     r_x;
    logic [11:0]     r_y;
    logic [3:0]      r_press_cnt;
    logic [3:0]      r_release_cnt;
    logic            r_valid;
    logic [9:0]      r_touch_x;
    logic [8:0]      r_touch_y;
    logic            r_strobe;

    logic            w_div_end;
    logic            w_tick;
    logic            w_pressed;
    logic            w_shift_done;
    logic            w_in_frame;
    logic [7:0]      w_cmd;
    logic            w_mosi;
    logic [3:0]      w_press_inc;
    logic [3:0]      w_release_inc;
    logic [9:0]      w_x_scaled;
    logic [9:0]      w_y_scaled;
    logic            w_unused;

    function automatic logic [9:0] scale_axis(
        input logic [11:0] raw,
        input logic [11:0] lo,
        input logic [11:0] hi,
        input logic [9:0]  scale,
        input logic [9:0]  sat
    );
        logic [11:0] c;
        logic [11:0] d;
        logic [21:0] p;
        logic [9:0]  r;
        if (raw < lo)
            c = lo;
        else if (raw > hi)
            c = hi;
        else
            c = raw;
        d = c - lo;
        p = 22'(d) * 22'(scale);
        r = p[21:12];
        if (r > sat)
            r = sat;
        return r;
    endfunction

    assign w_div_end    = (r_div == DW'(CLK_DIV - 1));
    assign w_tick       = (r_poll_cnt == PW'(POLL_CYCLES - 1));
    assign w_pressed    = (r_z >= 12'(Z_THRESH));
    assign w_shift_done = w_div_end && r_sclk && (r_bit == 5'd23);
    assign w_in_frame   = (r_state == S_SETUP) || (r_state == S_SHIFT) ||
                          (r_state == S_HOLD)  || (r_state == S_GAP);

    assign w_press_inc   = (r_press_cnt == 4'hF)   ? r_press_cnt   : r_press_cnt + 4'd1;
    assign w_release_inc = (r_release_cnt == 4'hF) ? r_release_cnt : r_release_cnt + 4'd1;

    assign w_x_scaled = scale_axis(r_x, 12'(X_MIN), 12'(X_MAX), 10'(X_SCALE), 10'd319);
    assign w_y_scaled = scale_axis(r_y, 12'(Y_MIN), 12'(Y_MAX), 10'(Y_SCALE), 10'd239);

    // Only rx[14:3] carries conversion data; the busy bit and trailing zeros are ignored.
    assign w_unused = ^{r_rx[15], r_rx[2:0], w_y_scaled[9]};

    always_comb begin
        case (r_ch)
            2'd0:    w_cmd = 8'hB0;
            2'd1:    w_cmd = 8'hD0;
            default: w_cmd = 8'h90;
        endcase
    end

    always_comb begin
        w_mosi = 1'b0;
        if (r_state == S_SETUP)
            w_mosi = w_cmd[7];
        else if ((r_state == S_SHIFT) && (r_bit[4:3] == 2'b00))
            w_mosi = w_cmd[~r_bit[2:0]];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (r_pending || w_tick) w_state_next = S_SETUP;
            S_SETUP: if (w_div_end) w_state_next = S_SHIFT;
            S_SHIFT: if (w_shift_done) w_state_next = S_HOLD;
            S_HOLD:  if (w_div_end) w_state_next = S_GAP;
            S_GAP: begin
                if (w_div_end) begin
                    if ((r_ch == 2'd2) || ((r_ch == 2'd0) && !w_pressed))
                        w_state_next = S_EVAL;
                    else
                        w_state_next = S_SETUP;
                end
            end
            S_EVAL:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_poll_cnt    <= '0;
            r_pending     <= 1'b0;
            r_div         <= '0;
            r_sclk        <= 1'b0;
            r_bit         <= '0;
            r_rx          <= '0;
            r_ch          <= '0;
            r_z           <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_press_cnt   <= '0;
            r_release_cnt <= '0;
            r_valid       <= 1'b0;
            r_touch_x     <= '0;
            r_touch_y     <= '0;
            r_strobe      <= 1'b0;
        end else begin
            r_poll_cnt <= w_tick ? '0 : r_poll_cnt + PW'(1);

            // IDLE consumes the request (held or arriving); a second one while busy is dropped.
            if (r_state == S_IDLE)
                r_pending <= 1'b0;
            else if (w_tick)
                r_pending <= 1'b1;

            r_div  <= (w_in_frame && !w_div_end) ? r_div + DW'(1) : '0;
            r_sclk <= (r_state == S_SHIFT) ? (r_sclk ^ w_div_end) : 1'b0;

            if (r_state != S_SHIFT)
                r_bit <= '0;
            else if (w_div_end && r_sclk)
                r_bit <= r_bit + 5'd1;

            if ((r_state == S_SHIFT) && w_div_end && !r_sclk && (r_bit >= 5'd8))
                r_rx <= {r_rx[14:0], spi_miso};

            if ((r_state == S_HOLD) && w_div_end) begin
                case (r_ch)
                    2'd0:    r_z <= r_rx[14:3];
                    2'd1:    r_x <= r_rx[14:3];
                    default: r_y <= r_rx[14:3];
                endcase
            end

            if (r_state == S_IDLE)
                r_ch <= '0;
            else if ((r_state == S_GAP) && w_div_end)
                r_ch <= r_ch + 2'd1;

            r_strobe <= (r_state == S_EVAL);

            if (r_state == S_EVAL) begin
                if (w_pressed) begin
                    r_press_cnt   <= w_press_inc;
                    r_release_cnt <= '0;
                    r_touch_x     <= w_x_scaled;
                    r_touch_y     <= w_y_scaled[8:0];
                    if (w_press_inc >= 4'(PRESS_COUNT))
                        r_valid <= 1'b1;
                end else begin
                    r_press_cnt   <= '0;
                    r_release_cnt <= w_release_inc;
                    if (w_release_inc >= 4'(RELEASE_COUNT))
                        r_valid <= 1'b0;
                end
            end
        end
    end

    assign spi_sclk      = r_sclk;
    assign spi_mosi      = w_mosi;
    assign spi_cs_n      = !((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD));
    assign touch_valid   = r_valid;
    assign touch_x       = r_touch_x;
    assign touch_y       = r_touch_y;
    assign sample_strobe = r_strobe;

endmodule

// File: tb/tb_touch_spi_reader.sv
// Directed self-checking bench for touch_spi_reader with a behavioural XPT2046
// model that decodes the command byte and returns 12-bit conversions.
module tb_touch_spi_reader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       miso = 1'b0;
    logic       spi_sclk, spi_mosi, spi_cs_n, touch_valid, sample_strobe;
    logic [9:0] touch_x;
    logic [8:0] touch_y;

    logic       ovr_reset_n;
    logic       o_sclk, o_mosi, o_cs_n, o_valid, o_strobe;
    logic [9:0] o_x;
    logic [8:0] o_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    touch_spi_reader #(.CLK_DIV(2), .POLL_CYCLES(2000)) dut (
        .clk(clk), .reset_n(reset_n), .spi_miso(miso),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .touch_valid(touch_valid), .touch_x(touch_x), .touch_y(touch_y),
        .sample_strobe(sample_strobe)
    );

    touch_spi_reader #(.CLK_DIV(2), .POLL_CYCLES(50)) dut_ovr (
        .clk(clk), .reset_n(ovr_reset_n), .spi_miso(1'b0),
        .spi_sclk(o_sclk), .spi_mosi(o_mosi), .spi_cs_n(o_cs_n),
        .touch_valid(o_valid), .touch_x(o_x), .touch_y(o_y),
        .sample_strobe(o_strobe)
    );

    // Controller model: commands captured on SCLK rises, data launched after SCLK falls.
    logic [11:0] m_z = 12'd10;
    logic [11:0] m_x = 12'd0;
    logic [11:0] m_y = 12'd0;
    logic [7:0]  m_cmd = 8'h00;
    logic [23:0] m_word;
    int          rcnt = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [7:0]  frame_q[$];

    function automatic logic [23:0] resp_word(input logic [7:0] c);
        logic [11:0] d;
        if (c == 8'hB0)
            d = m_z;
        else if (c == 8'hD0)
            d = m_x;
        else
            d = m_y;
        return {9'b0, d, 3'b000};
    endfunction

    function automatic logic [7:0] q_at(input int i);
        if (i < frame_q.size())
            return frame_q[i];
        return 8'hxx;
    endfunction

    always @(negedge clk) begin
        if (prev_cs && !spi_cs_n) begin
            rcnt  = 0;
            m_cmd = 8'h00;
            miso  = 1'b0;
        end else if (!spi_cs_n) begin
            if (!prev_sclk && spi_sclk) begin
                if (rcnt < 8)
                    m_cmd = {m_cmd[6:0], spi_mosi};
                rcnt++;
                if (rcnt == 8)
                    frame_q.push_back(m_cmd);
            end else if (prev_sclk && !spi_sclk && rcnt >= 8 && rcnt < 24) begin
                m_word = resp_word(m_cmd);
                miso   = m_word[23 - rcnt];
            end
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    task automatic wait_strobe(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sample_strobe === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: sample_strobe timeout, got none, required one within 3000 cycles", name);
        end
    endtask

    task automatic wait_cs_fall(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (spi_cs_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: cs_n never fell within 3000 cycles", name);
        end
    endtask

    task automatic test_reset;
        int n;
        int low;
        int base;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_sclk, spi_mosi, spi_cs_n, touch_valid, touch_x, touch_y, sample_strobe} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got sclk=%b mosi=%b cs_n=%b valid=%b x=%0d y=%0d strobe=%b, required 0 0 1 0 0 0 0",
                     spi_sclk, spi_mosi, spi_cs_n, touch_valid, touch_x, touch_y, sample_strobe);
        end
        base    = frame_q.size();
        reset_n = 1'b1;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (spi_cs_n === 1'b0)
                break;
        end
        checks++;
        if (n !== 2000) begin
            errors++;
            $display("FAIL first_poll: cs_n fell after %0d cycles, required 2000", n);
        end
        low = 1;
        while (spi_cs_n === 1'b0 && low < 500) begin
            @(negedge clk);
            if (spi_cs_n === 1'b0)
                low++;
        end
        checks++;
        if (low !== 100) begin
            errors++;
            $display("FAIL cs_low_len: cs_n low for %0d cycles, required 100", low);
        end
        wait_strobe("reset_poll");
        checks++;
        if (q_at(base) !== 8'hB0) begin
            errors++;
            $display("FAIL first_cmd: got 0x%02h, required 0xb0", q_at(base));
        end
        checks++;
        if (frame_q.size() - base !== 1 || touch_valid !== 1'b0) begin
            errors++;
            $display("FAIL released_poll: frames=%0d valid=%b, required frames=1 valid=0",
                     frame_q.size() - base, touch_valid);
        end
    endtask

    task automatic test_center;
        int n;
        int base;
        m_z = 12'h400;
        m_x = 12'd2050;
        m_y = 12'd2050;
        base = frame_q.size();
        wait_cs_fall("center_cs");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (spi_cs_n === 1'b0 && n < 300);
        while (spi_cs_n === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 102) begin
            errors++;
            $display("FAIL frame_period: cs_n fall-to-fall %0d cycles, required 102", n);
        end
        wait_strobe("center_poll1");
        checks++;
        if (touch_valid !== 1'b0) begin
            errors++;
            $display("FAIL center_poll1_valid: got %b, required 0", touch_valid);
        end
        checks++;
        if (frame_q.size() - base !== 3 || {q_at(base), q_at(base + 1), q_at(base + 2)} !== 24'hB0D090) begin
            errors++;
            $display("FAIL pressed_frames: got %0d frames %02h %02h %02h, required 3 frames b0 d0 90",
                     frame_q.size() - base, q_at(base), q_at(base + 1), q_at(base + 2));
        end
        checks++;
        if (touch_x !== 10'd159 || touch_y !== 9'd120) begin
            errors++;
            $display("FAIL center_poll1_xy: got (%0d,%0d), required (159,120)", touch_x, touch_y);
        end
        wait_strobe("center_poll2");
        checks++;
        if (touch_valid !== 1'b1 || touch_x !== 10'd159 || touch_y !== 9'd120) begin
            errors++;
            $display("FAIL center_poll2: got valid=%b (%0d,%0d), required valid=1 (159,120)",
                     touch_valid, touch_x, touch_y);
        end
    endtask

    task automatic test_clamp;
        m_x = 12'd4000;
        m_y = 12'd3900;
        wait_strobe("clamp_high");
        checks++;
        if (touch_x !== 10'd319 || touch_y !== 9'd239) begin
            errors++;
            $display("FAIL clamp_high: got (%0d,%0d), required (319,239)", touch_x, touch_y);
        end
        m_x = 12'd100;
        m_y = 12'd50;
        wait_strobe("clamp_low");
        checks++;
        if (touch_x !== 10'd0 || touch_y !== 9'd0) begin
            errors++;
            $display("FAIL clamp_low: got (%0d,%0d), required (0,0)", touch_x, touch_y);
        end
    endtask

    task automatic test_release;
        int base;
        m_x = 12'd2050;
        m_y = 12'd2050;
        wait_strobe("rel_setup");
        m_z = 12'd10;
        m_x = 12'd4000;
        m_y = 12'd4000;
        base = frame_q.size();
        wait_strobe("rel_single");
        checks++;
        if (touch_valid !== 1'b1 || touch_x !== 10'd159 || touch_y !== 9'd120) begin
            errors++;
            $display("FAIL release_single: got valid=%b (%0d,%0d), required valid=1 (159,120)",
                     touch_valid, touch_x, touch_y);
        end
        checks++;
        if (frame_q.size() - base !== 1 || q_at(base) !== 8'hB0) begin
            errors++;
            $display("FAIL release_frames1: got %0d frames first 0x%02h, required 1 frame 0xb0",
                     frame_q.size() - base, q_at(base));
        end
        m_z = 12'h400;
        m_x = 12'd2050;
        m_y = 12'd2050;
        wait_strobe("rel_repress");
        m_z = 12'd10;
        m_x = 12'd4000;
        base = frame_q.size();
        wait_strobe("rel_first");
        checks++;
        if (touch_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_first: valid got %b, required 1", touch_valid);
        end
        wait_strobe("rel_second");
        checks++;
        if (touch_valid !== 1'b0 || touch_x !== 10'd159 || touch_y !== 9'd120) begin
            errors++;
            $display("FAIL release_second: got valid=%b (%0d,%0d), required valid=0 (159,120)",
                     touch_valid, touch_x, touch_y);
        end
        checks++;
        if (frame_q.size() - base !== 2 || {q_at(base), q_at(base + 1)} !== 16'hB0B0) begin
            errors++;
            $display("FAIL release_frames2: got %0d frames %02h %02h, required 2 frames b0 b0",
                     frame_q.size() - base, q_at(base), q_at(base + 1));
        end
    endtask

    task automatic test_reset_mid_shift;
        int n;
        int base;
        m_z = 12'h400;
        m_x = 12'd2050;
        m_y = 12'd2050;
        wait_cs_fall("mid_cs");
        n = 0;
        while (rcnt < 12 && n < 300) begin
            @(negedge clk);
            n++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || touch_x !== 10'd0 || touch_y !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got cs_n=%b sclk=%b x=%0d y=%0d, required 1 0 0 0",
                     spi_cs_n, spi_sclk, touch_x, touch_y);
        end
        repeat (3) @(negedge clk);
        base    = frame_q.size();
        reset_n = 1'b1;
        wait_strobe("after_reset1");
        checks++;
        if (frame_q.size() - base !== 3 || {q_at(base), q_at(base + 1), q_at(base + 2)} !== 24'hB0D090) begin
            errors++;
            $display("FAIL after_reset_frames: got %0d frames %02h %02h %02h, required 3 frames b0 d0 90",
                     frame_q.size() - base, q_at(base), q_at(base + 1), q_at(base + 2));
        end
        checks++;
        if (touch_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_valid1: got %b, required 0", touch_valid);
        end
        wait_strobe("after_reset2");
        checks++;
        if (touch_valid !== 1'b1 || touch_x !== 10'd159 || touch_y !== 9'd120) begin
            errors++;
            $display("FAIL after_reset_valid2: got valid=%b (%0d,%0d), required valid=1 (159,120)",
                     touch_valid, touch_x, touch_y);
        end
    endtask

    task automatic test_overrun;
        int n;
        ovr_reset_n = 1'b1;
        n = 0;
        while (o_strobe !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_strobe !== 1'b1) begin
            errors++;
            $display("FAIL overrun_first: no strobe within 500 cycles");
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_strobe !== 1'b0) begin
                errors++;
                $display("FAIL overrun_width: strobe still %b one cycle later, required 0", o_strobe);
            end
            n = 1;
            while (o_strobe !== 1'b1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n !== 104) begin
                errors++;
                $display("FAIL overrun_spacing: strobe spacing %0d cycles, required 104", n);
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        ovr_reset_n = 1'b0;
        test_reset;
        test_center;
        test_clamp;
        test_release;
        test_reset_mid_shift;
        test_overrun;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
